row_shift_loader: RTL and testbench
===================================

// Module: row_shift_loader
// PURPOSE
//  Upstream feeder of the PWM stage. Accepts a serial byte stream via a valid/ready handshake.
//  Shifts STAGE bytes into a chain and latches the full row in parallel onto row_data.
//  Pulses hsync for one cycle so every PWM block reloads its duty value together.
// PARAMETERS
//  DWIDTH  8  bits per duty value, equal to PWM DWIDTH
//  STAGE   8  PWM channels per row; shift chain depth
//  RCWIDTH 16 width of the latched-row counter
// PORTS
//  clk         in   1             system clock, all logic on posedge
//  rst         in   1             asynchronous, active-low reset
//  start       in   1             level enable; sampled only in IDLE and at end of LATCH
//  din         in   DWIDTH        serial duty byte
//  din_valid   in   1             din is valid this cycle
//  din_ready   out  1             loader accepts din this cycle
//  period_end  in   1             1-cycle pulse from global counter at PWM period wrap
//  row_data    out  STAGE*DWIDTH  latched row; slice i = row_data[i*DWIDTH +: DWIDTH]
//  hsync       out  1             1-cycle pulse, high in first cycle new row_data is visible
//  busy        out  1             state != IDLE
//  row_cnt     out  RCWIDTH       rows latched since reset, wraps
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; shift chain, row_data, byte count, row_cnt all 0.
//   hsync=0, din_ready=0, busy=0. Reset mid-row discards partial data; no hsync is issued.
//  FSM states: IDLE, SHIFT, WAIT_PERIOD, LATCH. All outputs are registered except din_ready.
//  - IDLE:        start=1 -> SHIFT.
//  - SHIFT:       din_ready=1 (combinational from state). Transfer = din_valid & din_ready.
//                 On each transfer: chain[k] <= chain[k-1], chain[0] <= din, bcnt++.
//                 The transfer that makes bcnt==STAGE clears bcnt and leaves SHIFT.
//                 The first byte of a row therefore lands in chain[STAGE-1].
//                 din_valid=0 stalls with no change. start is ignored: a begun row always completes.
//  - WAIT_PERIOD: only with macro below; din_ready=0; period_end=1 -> LATCH.
//  - LATCH:       one cycle; din_ready=0. Next edge: row_data <= chain, hsync <= 1, row_cnt++.
//                 Next state = SHIFT if start=1, else IDLE.
//  hsync is high exactly one cycle, coincident with the first cycle of new row_data.
//  row_data holds its value until the next LATCH.
//  Latency without macro: last transfer at edge E0, LATCH during cycle after E0.
//   row_data and hsync update at E0+1.
//  row_cnt wraps from 2^RCWIDTH-1 to 0 without flag.
//  period_end in any state other than WAIT_PERIOD is ignored (not remembered).
//  The chain is not cleared between rows; all STAGE bytes are overwritten each row.
// CONFIGURATION
//  Macro LOADER_PERIOD_SYNC_EN.
//  Defined: after the last transfer go to WAIT_PERIOD; latch only after period_end is sampled there.
//   Each period shows a single duty value, with no mid-period glitch.
//  Undefined: WAIT_PERIOD is unreachable and not synthesised; last transfer -> LATCH directly.
//   period_end is unused.
// STRUCTURE
//  Package pwm_pkg:
//  - typedef enum logic [1:0] {IDLE, SHIFT, WAIT_PERIOD, LATCH} ldr_state_t;
//  - DWIDTH/STAGE defaults, shared with PWM
//  - localparam BCW = $clog2(STAGE+1)
//  One sub-module, stage_shreg: the STAGE x DWIDTH shift chain.
//   Ports: clk, rst, shift_en, din, parallel out.
//  FSM, byte counter, output latch and row_cnt live in the top module.
// TESTING
//  1. Macro off, start=1: send 8'h01..8'h08 back-to-back.
//     -> slice7=01 ... slice0=08; hsync one cycle at E0+1; row_cnt=1.
//  2. din_valid toggled 1/0 per cycle over one row.
//     -> exactly 8 transfers, same row_data as test 1, bytes neither dropped nor duplicated.
//  3. Macro on: full row sent, period_end delayed 20 cycles.
//     -> din_ready=0 and row_data unchanged while waiting.
//     -> hsync 2 edges after period_end is sampled in WAIT_PERIOD.
//  4. Assert rst=0 after 5 of 8 bytes, release, then send a new row of 8'hA0..8'hA7.
//     -> no hsync before reset; row_data=0 until the new row latches; row_cnt=1.
//  5. start dropped during SHIFT: row still completes and latches, then busy=0 in IDLE.
//  6. RCWIDTH=4: latch 17 rows -> row_cnt wraps to 0 after row 16, then reads 1.

Source files
------------

// File: rtl/row_shift_loader_pkg.sv
// Shared PWM/loader types and default geometry.
// Imported by the row loader, its interface and the shift-chain sub-module.
package pwm_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_STAGE  = 8;
    localparam int BCW        = $clog2(DEF_STAGE + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_PERIOD,
        LATCH
    } ldr_state_t;

endpackage

// File: rtl/row_shift_loader_if.sv
// Serial duty-byte stream: one DWIDTH-wide byte per cycle under valid/ready.
// master drives data, slave (the loader) returns ready.
interface row_shift_loader_if #(
    parameter int DWIDTH = pwm_pkg::DEF_DWIDTH
) ();

    logic [DWIDTH-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/row_shift_loader_stage_shreg.sv
// STAGE x DWIDTH shift chain; slice 0 takes din, slice k takes old slice k-1.
// Latency: one cycle per shift. Backpressure: none, shifts only when shift_en is high.
module stage_shreg #(
    parameter int DWIDTH = pwm_pkg::DEF_DWIDTH,
    parameter int STAGE  = pwm_pkg::DEF_STAGE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift_en,
    input  logic [DWIDTH-1:0]         din,
    output logic [STAGE*DWIDTH-1:0]   pout
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout <= '0;
        end else if (shift_en) begin
            pout <= {pout[(STAGE-1)*DWIDTH-1:0], din};
        end
    end

endmodule

// File: rtl/row_shift_loader.sv
// Row loader for the PWM stage: shifts STAGE serial bytes in, latches the row, pulses hsync.
// Latency: row_data/hsync update one edge after the last byte (or after period_end when
// LOADER_PERIOD_SYNC_EN is defined). Backpressure: din_ready low outside SHIFT.
module row_shift_loader
    import pwm_pkg::*;
#(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int STAGE   = DEF_STAGE,
    parameter int RCWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    row_shift_loader_if.slave        din_if,
    input  logic                     period_end,
    output logic [STAGE*DWIDTH-1:0]  row_data,
    output logic                     hsync,
    output logic                     busy,
    output logic [RCWIDTH-1:0]       row_cnt
);

    localparam int CW = (STAGE == DEF_STAGE) ? BCW : $clog2(STAGE + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(STAGE - 1);

    ldr_state_t                state;
    logic [CW-1:0]             bcnt;
    logic [STAGE*DWIDTH-1:0]   chain;
    logic                      xfer;

    assign din_if.din_ready = (state == SHIFT);
    assign xfer             = din_if.din_valid && din_if.din_ready;

    stage_shreg #(
        .DWIDTH (DWIDTH),
        .STAGE  (STAGE)
    ) u_chain (
        .clk      (clk),
        .rst      (rst),
        .shift_en (xfer),
        .din      (din_if.din),
        .pout     (chain)
    );

`ifndef LOADER_PERIOD_SYNC_EN
    logic unused_period_end;
    assign unused_period_end = period_end;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bcnt     <= '0;
            row_data <= '0;
            hsync    <= 1'b0;
            busy     <= 1'b0;
            row_cnt  <= '0;
        end else begin
            hsync <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                // start is deliberately ignored here so a begun row always completes
                SHIFT: begin
                    if (xfer) begin
                        if (bcnt == LAST_BYTE) begin
                            bcnt  <= '0;
`ifdef LOADER_PERIOD_SYNC_EN
                            state <= WAIT_PERIOD;
`else
                            state <= LATCH;
`endif
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
`ifdef LOADER_PERIOD_SYNC_EN
                WAIT_PERIOD: begin
                    if (period_end) state <= LATCH;
                end
`endif
                LATCH: begin
                    row_data <= chain;
                    hsync    <= 1'b1;
                    row_cnt  <= row_cnt + 1'b1;
                    if (start) begin
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_shift_loader.sv
// Bench for row_shift_loader: vector table, hand sequences and random traffic against a
// byte-level row model; a second instance with RCWIDTH=4 exercises row_cnt wrap.
`timescale 1ns/1ps
module tb_row_shift_loader;

    localparam int DW = 8;
    localparam int ST = 8;
    localparam int RW = 16;
    localparam int W  = DW * ST;
`ifdef LOADER_PERIOD_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic period_end = 1'b0;
    logic [W-1:0]  row_data, row_data4;
    logic          hsync, hsync4, busy, busy4;
    logic [RW-1:0] row_cnt;
    logic [3:0]    row_cnt4;

    int checks = 0;
    int errors = 0;

    row_shift_loader_if #(.DWIDTH(DW)) bus ();
    row_shift_loader_if #(.DWIDTH(DW)) bus4 ();
    assign bus4.din       = bus.din;
    assign bus4.din_valid = bus.din_valid;

    always #5 clk = ~clk;

    row_shift_loader #(.DWIDTH(DW), .STAGE(ST), .RCWIDTH(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .din_if(bus), .period_end(period_end),
        .row_data(row_data), .hsync(hsync), .busy(busy), .row_cnt(row_cnt)
    );

    row_shift_loader #(.DWIDTH(DW), .STAGE(ST), .RCWIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .din_if(bus4), .period_end(period_end),
        .row_data(row_data4), .hsync(hsync4), .busy(busy4), .row_cnt(row_cnt4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: rows as byte sequences ----------------
    localparam int M_IDLE = 0, M_ROW = 1, M_HOLD = 2, M_LATCH = 3;
    int            m_mode, m_n, m_cnt;
    logic [DW-1:0] m_buf [ST];
    logic [W-1:0]  m_row;
    bit            m_hs;

    // First byte of the row is the most significant slice.
    function automatic logic [W-1:0] assemble();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < ST; i++) r[i*DW +: DW] = m_buf[ST-1-i];
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= M_IDLE;
            m_n    <= 0;
            m_cnt  <= 0;
            m_row  <= '0;
            m_hs   <= 1'b0;
        end else begin
            m_hs <= 1'b0;
            case (m_mode)
                M_IDLE: if (start) m_mode <= M_ROW;
                M_ROW: if (bus.din_valid) begin
                    m_buf[m_n] <= bus.din;
                    if (m_n == ST - 1) begin
                        m_n    <= 0;
                        m_mode <= SYNC ? M_HOLD : M_LATCH;
                    end else begin
                        m_n <= m_n + 1;
                    end
                end
                M_HOLD: if (period_end) m_mode <= M_LATCH;
                default: begin
                    m_row  <= assemble();
                    m_hs   <= 1'b1;
                    m_cnt  <= m_cnt + 1;
                    m_mode <= start ? M_ROW : M_IDLE;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("din_ready", bus.din_ready, m_mode == M_ROW);
            chk("din_ready4", bus4.din_ready, m_mode == M_ROW);
            chk("busy", busy, m_mode != M_IDLE);
            chk("busy4", busy4, m_mode != M_IDLE);
            chk("hsync", hsync, m_hs);
            chk("hsync4", hsync4, m_hs);
            chk("row_data", row_data, m_row);
            chk("row_data4", row_data4, m_row);
            chk("row_cnt", row_cnt, m_cnt[RW-1:0]);
            chk("row_cnt4", row_cnt4, m_cnt[3:0]);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        bit st, vld, pe;
        logic [7:0] d;
        bit e_rdy, e_busy, e_hs;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit st, bit vld, bit pe, logic [7:0] d, bit r, bit b, bit h);
        vec_t v;
        v.st = st; v.vld = vld; v.pe = pe; v.d = d;
        v.e_rdy = r; v.e_busy = b; v.e_hs = h;
        tbl.push_back(v);
    endfunction

    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            bus.din_valid = 1'b1;
            bus.din       = first + 8'(k);
            @(negedge clk);
        end
        bus.din_valid = 1'b0;
    endtask

    // Returns at the negedge where hsync is high; an expired bound is a failed check.
    task automatic wait_hsync(input string name, input int bound);
        int n;
        n = 0;
        period_end = SYNC;
        bus.din_valid = 1'b0;
        while (!hsync && n < bound) begin
            @(negedge clk);
            n++;
        end
        period_end = 1'b0;
        chk(name, hsync, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din = '0;
        bus.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.din_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hsync", hsync, 1'b0);
        chk("rst_row_data", row_data, '0);
        chk("rst_row_cnt", row_cnt, '0);
        rst = 1'b1;

        // Test 1: back-to-back row 01..08
        add(1, 0, 0, 8'h00, 1, 1, 0);
        for (int k = 1; k <= 8; k++) add(1, 1, 0, 8'(k), k < 8, 1, 0);
        if (SYNC) begin
            for (int k = 0; k < 3; k++) add(1, 0, 0, 8'h00, 0, 1, 0);
            add(1, 0, 1, 8'h00, 0, 1, 0);
        end
        add(1, 0, 0, 8'h00, 1, 1, 1);
        add(0, 0, 1, 8'h00, 1, 1, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st;
            bus.din_valid = tbl[i].vld;
            bus.din = tbl[i].d;
            period_end = tbl[i].pe;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), bus.din_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_hsync", i), hsync, tbl[i].e_hs);
        end
        period_end = 1'b0;
        chk("t1_row_data", row_data, 64'h0102030405060708);
        chk("t1_row_cnt", row_cnt, 1);

        // Tests 2 and 5: valid toggling with start already dropped
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.din_valid = (i % 2 == 0);
            bus.din = (i % 2 == 0) ? 8'(i / 2 + 1) : 8'($urandom);
            @(negedge clk);
        end
        wait_hsync("t2_hsync", 40);
        chk("t2_row_data", row_data, 64'h0102030405060708);
        chk("t2_row_cnt", row_cnt, 2);
        @(negedge clk);
        chk("t5_busy", busy, 1'b0);
        chk("t5_ready", bus.din_ready, 1'b0);

`ifdef LOADER_PERIOD_SYNC_EN
        // Test 3: latch held off until period_end
        start = 1'b1;
        @(negedge clk);
        send_bytes(8'h11, 8);
        for (int i = 0; i < 20; i++) begin
            chk("t3_wait_ready", bus.din_ready, 1'b0);
            chk("t3_wait_row", row_data, 64'h0102030405060708);
            chk("t3_wait_hsync", hsync, 1'b0);
            @(negedge clk);
        end
        period_end = 1'b1;
        @(negedge clk);
        period_end = 1'b0;
        chk("t3_latch_hsync", hsync, 1'b0);
        @(negedge clk);
        chk("t3_hsync", hsync, 1'b1);
        chk("t3_row_data", row_data, 64'h1112131415161718);
`endif

        // Test 4: reset mid-row
        start = 1'b1;
        @(negedge clk);
        send_bytes(8'hA0, 5);
        rst = 1'b0;
        #1;
        chk("t4_rst_row", row_data, '0);
        chk("t4_rst_cnt", row_cnt, '0);
        chk("t4_rst_hsync", hsync, 1'b0);
        chk("t4_rst_busy", busy, 1'b0);
        chk("t4_rst_ready", bus.din_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_row_zero", row_data, '0);
        send_bytes(8'hA0, 8);
        wait_hsync("t4_hsync", 40);
        chk("t4_row_data", row_data, 64'hA0A1A2A3A4A5A6A7);
        chk("t4_row_cnt", row_cnt, 1);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            start = ($urandom % 5) != 0;
            bus.din_valid = ($urandom % 3) != 0;
            bus.din = 8'($urandom);
            period_end = ($urandom % 4) == 0;
            @(negedge clk);
        end
        bus.din_valid = 1'b0;
        period_end = 1'b0;

        // Test 6: row_cnt wrap on the 4-bit instance
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        for (int r = 1; r <= 17; r++) begin
            send_bytes(8'($urandom), 8);
            wait_hsync($sformatf("t6_hsync%0d", r), 40);
            chk($sformatf("t6_cnt4_%0d", r), row_cnt4, r % 16);
            chk($sformatf("t6_cnt_%0d", r), row_cnt, r);
        end

        start = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
